receiver: RTL and testbench
===========================

# receiver

Serial frame receiver that sits directly downstream of the `machine` transmitter and consumes its `txd` line. It deserialises frames and presents each byte on a held-valid/ack output register:

- Frame format: start bit `1`, 8 data bits LSB first, stop bit `0`.
- Idle line level is `0`.
- It flags framing errors and overruns.
- At the default one-bit-per-clock rate it pairs directly with the transmitter in the same clock domain.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal range 1..1023.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `rxd`  input  1  serial line; idle `0`, start `1`, stop `0`.
- `ack`  input  1  consumer acknowledges the byte currently in `data`.
- `data`  output  8  last received byte.
- `data_valid`  output  1  `data` holds an unacknowledged byte.
- `frame_error`  output  1  one-cycle pulse when the stop bit is not `0`.
- `overrun`  output  1  sticky: a byte completed while `data_valid` was high and no `ack` was present.

## Operation

- States:
  - `IDLE`: wait for `rxd==1`; on detection go to `START` and load the bit counter with `CLKS_PER_BIT/2` (floor).
  - `START`: count down to the start-bit midpoint, then re-sample `rxd`. If `1`, go to `DATA` with index 0. If `0`, treat it as a glitch and return to `IDLE`. With `CLKS_PER_BIT=1` the midpoint is the detection cycle itself, so `START` is skipped and `IDLE` goes directly to `DATA`.
  - `DATA`: sample `rxd` every `CLKS_PER_BIT` cycles into shift bit `index`. Index 0..7 uses a 3-bit counter. After index 7 is sampled (index wraps to 0), go to `STOP`.
  - `STOP`: sample `rxd` at the stop-bit midpoint, commit the frame as below, then go to `IDLE`.
- Commit, on the stop-sample edge:
  - If `data_valid==0`, or `ack==1` on that same edge: load `data` from the shift register and set `data_valid=1`.
  - Otherwise: discard the byte, set `overrun=1`, and leave `data` unchanged.
- `ack` with `data_valid==1` and no commit on that edge clears `data_valid` on that edge. `ack` while `data_valid==0` is ignored.
- `IDLE` is re-entered on the stop-sample edge. Because the stop level is `0`, the remainder of the stop bit does not retrigger reception.
- `rst` takes effect in any state, including mid-frame. It forces `IDLE`, clears the shift register, index and bit counter, and sets `data=0x00`, `data_valid=0`, `frame_error=0` and `overrun=0`.

## Timing

- Reset values: `data=0x00`, `data_valid=0`, `frame_error=0`, `overrun=0`.
- Let edge T be the edge at which `IDLE` first sees `rxd==1`.
- Data bit i is sampled at edge T + `CLKS_PER_BIT`*(i+1) + `CLKS_PER_BIT/2`.
- The stop bit is sampled at edge T + 9*`CLKS_PER_BIT` + `CLKS_PER_BIT/2`.
- With `CLKS_PER_BIT=1`:
  - Bits are sampled at T+1..T+8 and the stop bit at T+9.
  - `data`/`data_valid` are visible after T+9.
  - A new start bit can be detected at T+10.
- Against `machine` driving `rxd`: the edge at which its `txd` first reads `1` is T.
- `frame_error` is high for exactly the one cycle after the stop-sample edge.
- Back-to-back frames with no idle gap are received without loss at any `CLKS_PER_BIT`.

## Configuration

- `RECEIVER_FRAME_CHECK_EN` defined:
  - A stop sample of `1` pulses `frame_error` and discards the byte: no commit, `data_valid` and `overrun` unchanged.
  - The FSM returns to `IDLE`, which then waits for the line to read `0` before accepting a new start bit.
- `RECEIVER_FRAME_CHECK_EN` undefined:
  - The stop sample is ignored, every frame commits, and `frame_error` is tied to `0`.

## Test plan

- Reset then idle: `rst=1` for 2 cycles, then `rxd=0` for 20 cycles → `data=0x00`, `data_valid=0`, `frame_error=0`, `overrun=0` throughout.
- `CLKS_PER_BIT=1`: drive `rxd` = 1,1,0,1,0,0,1,0,1,0 starting at edge T → after T+9, `data=0xA5` and `data_valid=1`. `ack` pulsed at T+12 → `data_valid=0` after T+12.
- `CLKS_PER_BIT=1`: frames 0x3C then 0x81 back-to-back with no `ack` → `data=0x3C`, `data_valid=1`, `overrun=1` after the second stop edge. Repeat with `ack=1` on the second stop edge → `data=0x81`, `data_valid=1`, `overrun=0`.
- `RECEIVER_FRAME_CHECK_EN` defined: frame 0x55 with stop bit `1` → one-cycle `frame_error`, `data_valid=0`, `data=0x00`.
- Same frame with the macro undefined → `data=0x55`, `data_valid=1`, `frame_error=0`.
- `CLKS_PER_BIT=4`: a 1-cycle `rxd=1` glitch → no reception. A full frame 0xF0 → `data=0xF0`. `rst` asserted at bit 4 of a frame → all outputs 0 next cycle, and the following clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/receiver.sv
// Serial frame receiver: start '1', 8 data bits LSB first, stop '0', idle '0'.
// Optional stop-bit checking is enabled with `define RECEIVER_FRAME_CHECK_EN.
module receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun
);
  localparam int CW = 10;
  localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT / 2 - 1) : '0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          dv_q, ovr_q, fe_q, wait_low_q;
  logic          start_det, stop_bad;

`ifdef RECEIVER_FRAME_CHECK_EN
  // After a bad stop the line must return low before a new start is accepted.
  assign start_det = rxd && !wait_low_q;
  assign stop_bad  = rxd;
`else
  assign start_det = rxd;
  assign stop_bad  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      wait_low_q <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      if (ack && dv_q) dv_q <= 1'b0;   // a commit below on this edge takes priority
      if (!rxd) wait_low_q <= 1'b0;
      case (state_q)
        IDLE: if (start_det) begin
          idx_q <= '0;
          if (CLKS_PER_BIT == 1) begin
            state_q <= DATA;
            cnt_q   <= '0;
          end else begin
            state_q <= START;
            cnt_q   <= HALF_M1;
          end
        end
        START: if (cnt_q == '0) begin
          state_q <= rxd ? DATA : IDLE;
          cnt_q   <= FULL;
          idx_q   <= '0;
        end else cnt_q <= cnt_q - 1'b1;
        DATA: if (cnt_q == '0) begin
          shift_q[idx_q] <= rxd;
          idx_q          <= idx_q + 1'b1;
          cnt_q          <= FULL;
          if (idx_q == 3'd7) state_q <= STOP;
        end else cnt_q <= cnt_q - 1'b1;
        STOP: if (cnt_q == '0) begin
          state_q <= IDLE;
          if (stop_bad) begin
            fe_q       <= 1'b1;
            wait_low_q <= 1'b1;
          end else if (!dv_q || ack) begin
            data_q <= shift_q;
            dv_q   <= 1'b1;
          end else ovr_q <= 1'b1;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign frame_error = fe_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver at CLKS_PER_BIT=1 and 4 with a byte scoreboard.
module tb_receiver;
  logic clk = 1'b0, rst = 1'b0;
  logic rxd1 = 1'b0, ack1 = 1'b0, rxd4 = 1'b0, ack4 = 1'b0;
  logic [7:0] data1, data4;
  logic dv1, fe1, ovr1, dv4, fe4, ovr4;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  receiver #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .rxd(rxd1), .ack(ack1),
    .data(data1), .data_valid(dv1), .frame_error(fe1), .overrun(ovr1));
  receiver #(.CLKS_PER_BIT(4)) u4 (.clk(clk), .rst(rst), .rxd(rxd4), .ack(ack4),
    .data(data4), .data_valid(dv4), .frame_error(fe4), .overrun(ovr4));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b, input logic stopb, input logic ack_stop);
    logic [9:0] f;
    f = {stopb, b, 1'b1};
    for (int i = 0; i < 10; i++) begin
      rxd1 = f[i];
      if (i == 9) ack1 = ack_stop;
      tick();
      ack1 = 1'b0;
    end
    rxd1 = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b, input int nbits);
    logic [9:0] f;
    f = {1'b0, b, 1'b1};
    for (int i = 0; i < nbits; i++) begin
      rxd4 = f[i];
      for (int k = 0; k < 4; k++) tick();
    end
    rxd4 = 1'b0;
  endtask

  initial begin
    // reset then idle line
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("idle_data", data1, 8'h00);
      chk("idle_dv", {7'd0, dv1}, 8'd0);
      chk("idle_fe", {7'd0, fe1}, 8'd0);
      chk("idle_ovr", {7'd0, ovr1}, 8'd0);
      tick();
    end

    // single frame 0xA5, ack at T+12
    exp_q.push_back(8'hA5);
    send1(8'hA5, 1'b0, 1'b0);
    chk_pop("a5_data", data1);
    chk("a5_dv", {7'd0, dv1}, 8'd1);
    tick();
    chk("a5_dv_t10", {7'd0, dv1}, 8'd1);
    tick();
    chk("a5_dv_t11", {7'd0, dv1}, 8'd1);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("a5_dv_ack", {7'd0, dv1}, 8'd0);
    chk("a5_ovr", {7'd0, ovr1}, 8'd0);

    // back-to-back, no ack: second byte overruns
    do_reset();
    exp_q.push_back(8'h3C);
    send1(8'h3C, 1'b0, 1'b0);
    chk("b2b_first", data1, 8'h3C);
    send1(8'h81, 1'b0, 1'b0);
    chk_pop("b2b_data", data1);
    chk("b2b_dv", {7'd0, dv1}, 8'd1);
    chk("b2b_ovr", {7'd0, ovr1}, 8'd1);

    // back-to-back with ack on second stop edge
    do_reset();
    send1(8'h3C, 1'b0, 1'b0);
    exp_q.push_back(8'h81);
    send1(8'h81, 1'b0, 1'b1);
    chk_pop("b2b_ack_data", data1);
    chk("b2b_ack_dv", {7'd0, dv1}, 8'd1);
    chk("b2b_ack_ovr", {7'd0, ovr1}, 8'd0);

    // bad stop bit
    do_reset();
`ifdef RECEIVER_FRAME_CHECK_EN
    send1(8'h55, 1'b1, 1'b0);
    chk("fe_pulse", {7'd0, fe1}, 8'd1);
    chk("fe_dv", {7'd0, dv1}, 8'd0);
    chk("fe_data", data1, 8'h00);
    tick();
    chk("fe_pulse_end", {7'd0, fe1}, 8'd0);
    chk("fe_ovr", {7'd0, ovr1}, 8'd0);
`else
    exp_q.push_back(8'h55);
    send1(8'h55, 1'b1, 1'b0);
    chk_pop("nofe_data", data1);
    chk("nofe_dv", {7'd0, dv1}, 8'd1);
    chk("nofe_fe", {7'd0, fe1}, 8'd0);
    tick();
    chk("nofe_fe_next", {7'd0, fe1}, 8'd0);
`endif

    // CLKS_PER_BIT=4: glitch rejection
    do_reset();
    rxd4 = 1'b1; tick(); rxd4 = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("glitch_dv", {7'd0, dv4}, 8'd0);
    chk("glitch_data", data4, 8'h00);

    exp_q.push_back(8'hF0);
    send4(8'hF0, 10);
    chk_pop("c4_f0_data", data4);
    chk("c4_f0_dv", {7'd0, dv4}, 8'd1);

    // reset in the middle of data bit 4
    send4(8'hAA, 5);
    rxd4 = 1'b1; tick(); tick();
    rst = 1'b1; rxd4 = 1'b0; tick(); rst = 1'b0;
    chk("mid_rst_data", data4, 8'h00);
    chk("mid_rst_dv", {7'd0, dv4}, 8'd0);
    chk("mid_rst_ovr", {7'd0, ovr4}, 8'd0);
    chk("mid_rst_fe", {7'd0, fe4}, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    exp_q.push_back(8'h0F);
    send4(8'h0F, 10);
    chk_pop("c4_0f_data", data4);
    chk("c4_0f_dv", {7'd0, dv4}, 8'd1);
    chk("c4_0f_ovr", {7'd0, ovr4}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
